// File: rtl/score_bcd_converter.sv
`default_nettype none
// ============================================================================
//  Module      : score_bcd_converter
//  Description : Serial double-dabble converter turning the current score and
//                the high score into registered 4-digit BCD, one bit per clock.
//                Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros
//                with code 4'hF.
//  Revision    : 1.0 - initial release
// ============================================================================
module score_bcd_converter #(
    parameter int IN_W    = 14,
    parameter int MAX_VAL = 9999
) (
    input  logic            clock_100Mhz,
    input  logic            reset,
    input  logic [IN_W-1:0] score_in,
    input  logic [IN_W-1:0] high_in,
    output logic            busy,
    output logic            done,
    output logic [15:0]     bcd_score,
    output logic [15:0]     bcd_high,
    output logic            overflow
);

    localparam int              c_cnt_w   = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam logic [IN_W-1:0] c_max     = IN_W'(MAX_VAL);
    localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(IN_W - 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_load  = 2'd1;
    localparam logic [1:0] c_st_shift = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [c_cnt_w-1:0] r_cnt;

    logic [IN_W-1:0]    r_bin_s;
    logic [IN_W-1:0]    r_bin_h;
    logic [15:0]        r_bcd_s;
    logic [15:0]        r_bcd_h;
    logic [IN_W-1:0]    r_last_s;
    logic [IN_W-1:0]    r_last_h;
    logic               r_ovf_work;

    logic [IN_W-1:0]    w_sat_s;
    logic [IN_W-1:0]    w_sat_h;
    logic               w_ovf_in;
    logic [15:0]        w_adj_s;
    logic [15:0]        w_adj_h;
    logic [15:0]        w_fin_s;
    logic [15:0]        w_fin_h;
    logic               w_mismatch;
    logic               w_load;
    logic               w_shift;
    logic               w_finish;

    // Double-dabble correction: any digit >= 5 gets +3 before the shift.
    function automatic logic [15:0] add3_adjust(input logic [15:0] d);
        logic [15:0] r;
        r = d;
        for (int i = 0; i < 4; i++) begin
            if (d[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = d[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    // Scan thousands downward; the units digit always stays visible.
    function automatic logic [15:0] blank_leading(input logic [15:0] d);
        logic [15:0] r;
        logic        lead;
        r    = d;
        lead = 1'b1;
        for (int i = 3; i >= 1; i--) begin
            if (lead && (d[i*4 +: 4] == 4'd0)) begin
                r[i*4 +: 4] = 4'hF;
            end else begin
                lead = 1'b0;
            end
        end
        return r;
    endfunction

    assign w_fin_s = blank_leading(r_bcd_s);
    assign w_fin_h = blank_leading(r_bcd_h);
`else
    assign w_fin_s = r_bcd_s;
    assign w_fin_h = r_bcd_h;
`endif

    assign w_sat_s    = (score_in > c_max) ? c_max : score_in;
    assign w_sat_h    = (high_in  > c_max) ? c_max : high_in;
    assign w_ovf_in   = (score_in > c_max) || (high_in > c_max);
    assign w_adj_s    = add3_adjust(r_bcd_s);
    assign w_adj_h    = add3_adjust(r_bcd_h);
    // Last-converted copies hold the raw inputs so a saturated value does not
    // retrigger a conversion every time IDLE compares.
    assign w_mismatch = (score_in != r_last_s) || (high_in != r_last_h);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle:  if (w_mismatch) w_next_state = c_st_load;
            c_st_load:  w_next_state = c_st_shift;
            c_st_shift: if (r_cnt == '0) w_next_state = c_st_done;
            c_st_done:  w_next_state = c_st_idle;
            default:    w_next_state = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_load   = 1'b0;
        w_shift  = 1'b0;
        w_finish = 1'b0;
        case (r_state)
            c_st_load:  w_load   = 1'b1;
            c_st_shift: w_shift  = 1'b1;
            c_st_done:  w_finish = 1'b1;
            default:    ;
        endcase
    end

    // ------------------------------------------------------------------
    // Conversion datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            r_cnt      <= '0;
            r_bin_s    <= '0;
            r_bin_h    <= '0;
            r_bcd_s    <= '0;
            r_bcd_h    <= '0;
            r_last_s   <= '0;
            r_last_h   <= '0;
            r_ovf_work <= 1'b0;
        end else if (w_load) begin
            r_cnt      <= c_cnt_init;
            r_bin_s    <= w_sat_s;
            r_bin_h    <= w_sat_h;
            r_bcd_s    <= '0;
            r_bcd_h    <= '0;
            r_last_s   <= score_in;
            r_last_h   <= high_in;
            r_ovf_work <= w_ovf_in;
        end else if (w_shift) begin
            r_cnt                <= r_cnt - c_cnt_w'(1);
            {r_bcd_s, r_bin_s}   <= {w_adj_s, r_bin_s} << 1;
            {r_bcd_h, r_bin_h}   <= {w_adj_h, r_bin_h} << 1;
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs: only a completed conversion ever reaches them
    // ------------------------------------------------------------------
    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            bcd_score <= '0;
            bcd_high  <= '0;
            overflow  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (w_load) begin
                busy <= 1'b1;
            end
            if (w_finish) begin
                busy      <= 1'b0;
                done      <= 1'b1;
                bcd_score <= w_fin_s;
                bcd_high  <= w_fin_h;
                overflow  <= r_ovf_work;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_score_bcd_converter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_score_bcd_converter
//  Description : Directed self-checking bench for score_bcd_converter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_score_bcd_converter;

    localparam int IN_W = 14;

    localparam logic [15:0] c_exp_1234 = 16'h1234;
    localparam logic [15:0] c_exp_5678 = 16'h5678;
    localparam logic [15:0] c_exp_9999 = 16'h9999;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [15:0] c_exp_40   = 16'hFF40;
    localparam logic [15:0] c_exp_0    = 16'hFFF0;
    localparam logic [15:0] c_exp_4    = 16'hFFF4;
    localparam logic [15:0] c_exp_8    = 16'hFFF8;
`else
    localparam logic [15:0] c_exp_40   = 16'h0040;
    localparam logic [15:0] c_exp_0    = 16'h0000;
    localparam logic [15:0] c_exp_4    = 16'h0004;
    localparam logic [15:0] c_exp_8    = 16'h0008;
`endif

    // Counted from the input change: one edge to detect, then 16 more.
    localparam int c_lat = IN_W + 3;

    logic            clock_100Mhz = 1'b0;
    logic            reset        = 1'b1;
    logic [IN_W-1:0] score_in     = '0;
    logic [IN_W-1:0] high_in      = '0;
    logic            busy;
    logic            done;
    logic [15:0]     bcd_score;
    logic [15:0]     bcd_high;
    logic            overflow;

    int checks   = 0;
    int failures = 0;

    score_bcd_converter #(.IN_W(IN_W), .MAX_VAL(9999)) dut (
        .clock_100Mhz (clock_100Mhz),
        .reset        (reset),
        .score_in     (score_in),
        .high_in      (high_in),
        .busy         (busy),
        .done         (done),
        .bcd_score    (bcd_score),
        .bcd_high     (bcd_high),
        .overflow     (overflow)
    );

    always #5 clock_100Mhz = ~clock_100Mhz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_100Mhz);
        #1;
    endtask

    task automatic wait_done(output int cyc, output bit saw_busy);
        cyc      = 0;
        saw_busy = 1'b0;
        while (cyc < 60) begin
            tick();
            cyc++;
            if (busy) saw_busy = 1'b1;
            if (done) break;
        end
    endtask

    always @(negedge clock_100Mhz) begin
        check("busy_done_exclusive", 32'(busy & done), 32'd0);
    end

    initial begin
        int cyc;
        bit sb;
        bit saw;

        // Reset state
        reset = 1'b1;
        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bcd_score", 32'(bcd_score), 32'd0);
        check("rst_bcd_high", 32'(bcd_high), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);

        // Zero inputs match the reset copies: nothing happens
        reset = 1'b0;
        saw   = 1'b0;
        repeat (100) begin
            tick();
            if (done || busy) saw = 1'b1;
        end
        check("idle_no_activity", 32'(saw), 32'd0);
        check("idle_bcd_score", 32'(bcd_score), 32'd0);
        check("idle_bcd_high", 32'(bcd_high), 32'd0);

        // Basic conversion
        score_in = 14'd1234;
        high_in  = 14'd5678;
        wait_done(cyc, sb);
        check("conv1_latency", 32'(cyc), 32'(c_lat));
        check("conv1_busy_seen", 32'(sb), 32'd1);
        check("conv1_score", 32'(bcd_score), 32'(c_exp_1234));
        check("conv1_high", 32'(bcd_high), 32'(c_exp_5678));
        check("conv1_overflow", 32'(overflow), 32'd0);
        tick();
        check("conv1_done_pulse", 32'(done), 32'd0);
        check("conv1_busy_after", 32'(busy), 32'd0);

        // Exactly MAX_VAL
        score_in = 14'd9999;
        wait_done(cyc, sb);
        check("max_latency", 32'(cyc), 32'(c_lat));
        check("max_score", 32'(bcd_score), 32'(c_exp_9999));
        check("max_overflow", 32'(overflow), 32'd0);

        // MAX_VAL+1 saturates
        score_in = 14'd10000;
        wait_done(cyc, sb);
        check("sat_latency", 32'(cyc), 32'(c_lat));
        check("sat_score", 32'(bcd_score), 32'(c_exp_9999));
        check("sat_high", 32'(bcd_high), 32'(c_exp_5678));
        check("sat_overflow", 32'(overflow), 32'd1);

        // Leading zeros and zero value; overflow clears
        score_in = 14'd40;
        high_in  = 14'd0;
        wait_done(cyc, sb);
        check("lz_latency", 32'(cyc), 32'(c_lat));
        check("lz_score", 32'(bcd_score), 32'(c_exp_40));
        check("lz_high", 32'(bcd_high), 32'(c_exp_0));
        check("lz_overflow", 32'(overflow), 32'd0);

        // Input change mid-conversion is picked up by the next conversion
        score_in = 14'd4;
        repeat (5) tick();
        score_in = 14'd8;
        wait_done(cyc, sb);
        check("mid_first_latency", 32'(cyc), 32'(c_lat - 5));
        check("mid_first_score", 32'(bcd_score), 32'(c_exp_4));
        wait_done(cyc, sb);
        check("mid_second_latency", 32'(cyc), 32'(IN_W + 3));
        check("mid_second_busy_seen", 32'(sb), 32'd1);
        check("mid_second_score", 32'(bcd_score), 32'(c_exp_8));

        // Reset during SHIFT aborts, then the held inputs reconvert
        score_in = 14'd1234;
        repeat (5) tick();
        check("abort_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_score", 32'(bcd_score), 32'd0);
        check("abort_high", 32'(bcd_high), 32'd0);
        check("abort_overflow", 32'(overflow), 32'd0);
        saw = 1'b0;
        repeat (2) begin
            tick();
            if (done) saw = 1'b1;
        end
        check("abort_no_done", 32'(saw), 32'd0);
        reset = 1'b0;
        wait_done(cyc, sb);
        check("restart_latency", 32'(cyc), 32'(c_lat));
        check("restart_score", 32'(bcd_score), 32'(c_exp_1234));
        check("restart_high", 32'(bcd_high), 32'(c_exp_0));

        // Unchanged inputs: outputs hold with no further done
        saw = 1'b0;
        repeat (40) begin
            tick();
            if (done || busy) saw = 1'b1;
        end
        check("hold_no_activity", 32'(saw), 32'd0);
        check("hold_score", 32'(bcd_score), 32'(c_exp_1234));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/score_bcd_converter.md
Name: score_bcd_converter

Overview:
- Sequential binary-to-BCD converter using serial double-dabble. Sits between the score/high-score registers and the 7-segment digit multiplexer.
- Converts the current score and the high score in parallel, one bit per clock.
- Presents eight registered BCD digits that stay stable between conversions.
- Replaces the combinational modulo/divide chain feeding the scoreboard.

Parameters:
- IN_W, 14: width of each binary input; 14 bits covers 0..9999 plus overflow headroom.
- MAX_VAL, 9999: largest displayable value; larger inputs saturate to this.

Ports:
- clock_100Mhz  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-high
- score_in  input  IN_W  current score, binary
- high_in  input  IN_W  high score, binary
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse when the BCD outputs update
- bcd_score  output  16  score digits {thousands, hundreds, tens, units}, 4 bits each
- bcd_high  output  16  high-score digits, same packing
- overflow  output  1  high if either value last converted exceeded MAX_VAL

Behaviour:
- Reset values: busy=0, done=0, bcd_score=0, bcd_high=0, overflow=0; state IDLE.
- Internal last-converted copies of score and high are also reset to 0.
- Reset asserted mid-conversion aborts immediately. No partial result ever reaches the outputs.
- States and transitions:
  - IDLE: on each edge, compare score_in/high_in with the last-converted copies. On any mismatch go to LOAD.
  - LOAD: capture both inputs into working and last-converted registers.
    - Saturation: an input > MAX_VAL is replaced by MAX_VAL and an overflow flag is latched.
    - Clear the 16-bit BCD accumulators, set the bit counter to IN_W-1, set busy=1.
  - SHIFT: each cycle, for every BCD nibble >= 5 add 3, then shift {bcd, bin} left by 1.
    - Both values are processed in the same cycle.
    - Counter decrements; after IN_W shift cycles go to DONE.
  - DONE: register the accumulators to bcd_score/bcd_high and the flag to overflow. Pulse done=1, busy=0, return to IDLE.
- Latency: outputs and done appear exactly IN_W+2 edges after the first IDLE edge that sees a mismatch. This is 16 cycles for IN_W=14.
- Inputs changing during LOAD/SHIFT/DONE are ignored. The IDLE compare after DONE triggers a fresh conversion.
  - Worst case: the displayed value is two conversions (≤ 2*(IN_W+3) cycles) behind.
- Inputs unchanged: no conversion and no done pulse. Outputs hold indefinitely.
- Values equal to MAX_VAL: converted normally to 9,9,9,9 with overflow=0.
- Values of MAX_VAL+1 and above: output 9,9,9,9 with overflow=1.
- Each nibble of the outputs is always in the range 0..9, except the blank code described under Optional Feature.
- done and busy are never high in the same cycle.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: in DONE, leading zero digits of each value are replaced by 4'hF (blank code for the digit mux). The scan runs from thousands downward and stops at the first non-zero digit. The units digit is never blanked, so value 0 displays as F,F,F,0.
- Undefined: all digits are output as plain BCD, so value 0 displays as 0,0,0,0. No 4'hF code is ever produced.

Test Plan:
- Reset, then hold score_in=0, high_in=0 for 100 cycles -> bcd_score=0000, bcd_high=0000, done never pulses, busy stays 0.
- score_in=1234, high_in=5678 -> done pulses exactly 16 cycles later; bcd_score=16'h1234, bcd_high=16'h5678, overflow=0.
- score_in=9999, then 10000 -> first conversion gives 16'h9999 with overflow=0; second gives 16'h9999 with overflow=1.
- Change score_in 4→8 five cycles into a conversion -> first done gives 0004, a second done follows 17 cycles later with 0008, and busy re-asserts in between.
- Assert reset during the SHIFT state -> all outputs 0 on the next sample, busy=0, no done pulse. After release, the conversion of the held inputs restarts from LOAD.
- With LEADING_ZERO_BLANK_EN, score_in=40 and high_in=0 -> bcd_score=16'hFF40, bcd_high=16'hFFF0. Without the macro -> 16'h0040 and 16'h0000.
